// File: rtl/pid_pkg.sv
// Shared widths, the stage-2 record and the signed saturate helper
// used throughout the heading controller.
package pid_pkg;
    localparam int HDNG_W  = 12;
    localparam int FRWRD_W = 10;
    localparam int ERR_W   = 10;
    localparam int INTEG_W = 16;
    localparam int ITERM_W = 12;
    localparam int P_W     = 14;
    localparam int DDIFF_W = 7;
    localparam int D_W     = 13;
    localparam int PID_W   = 14;
    localparam int SPD_W   = 11;

    typedef struct packed {
        logic signed [P_W-1:0] p_term;
        logic signed [D_W-1:0] d_term;
    } s2_t;

    // Clamp a signed value into the range of a w-bit signed number.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction
endpackage

// File: rtl/heading_pid_if.sv
// Heading sample in, wheel speed commands and at-heading flag out.
interface heading_pid_if;
    import pid_pkg::*;

    logic signed [HDNG_W-1:0]  actl_hdng;
    logic                      hdng_vld;
    logic signed [HDNG_W-1:0]  dsrd_hdng;
    logic                      moving;
    logic        [FRWRD_W-1:0] frwrd;
    logic signed [SPD_W-1:0]   lft_spd;
    logic signed [SPD_W-1:0]   rght_spd;
    logic                      spd_vld;
    logic                      at_hdng;

    modport master (
        output actl_hdng, hdng_vld, dsrd_hdng, moving, frwrd,
        input  lft_spd, rght_spd, spd_vld, at_hdng
    );
    modport slave (
        input  actl_hdng, hdng_vld, dsrd_hdng, moving, frwrd,
        output lft_spd, rght_spd, spd_vld, at_hdng
    );
endinterface

// File: rtl/pid_integrator.sv
// Error accumulator: holds on signed overflow, cleared while not moving.
module pid_integrator
    import pid_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      moving,
    input  logic                      en,
    input  logic signed [ERR_W-1:0]   err,
    output logic signed [ITERM_W-1:0] i_term
);
    logic signed [INTEG_W-1:0] integ, err_x, sum;
    logic                      ovf;

    always_comb begin
        err_x = INTEG_W'(err);
        sum   = integ + err_x;
        ovf   = (integ[INTEG_W-1] == err_x[INTEG_W-1]) && (sum[INTEG_W-1] != integ[INTEG_W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          integ <= '0;
        else if (!moving)    integ <= '0;
        else if (en && !ovf) integ <= sum;
    end

    assign i_term = integ[INTEG_W-1:INTEG_W-ITERM_W];
endmodule

// File: rtl/heading_pid.sv
// Three-stage P+I+D heading loop: error/at-heading, P/D/integrate,
// then mix with forward speed into saturated left/right commands.
module heading_pid
    import pid_pkg::*;
#(
    parameter int P_COEFF        = 3,
    parameter int D_COEFF        = 14,
    parameter int D_QUEUE_DEPTH  = 2,
    parameter int AT_HDNG_THRESH = 30
) (
    input  logic         clk,
    input  logic         rst_n,
    heading_pid_if.slave bus
);
    localparam int STAGES = 2;

    // vld_pipe[0]: stage-1 result valid, [1]: stage-2 valid, [2]: spd_vld
    logic [STAGES:0]                     vld_pipe;
    logic signed [HDNG_W-1:0]            err;
    logic signed [ERR_W-1:0]             err_sat_d, err_sat_q;
    int                                  abs_err;
    logic                                at_hdng_q;
    logic [D_QUEUE_DEPTH-1:0][ERR_W-1:0] d_queue;
    logic signed [DDIFF_W-1:0]           d_diff;
    s2_t                                 s2_d, s2_q;
    logic signed [ITERM_W-1:0]           i_term;
    logic signed [PID_W-1:0]             pid;
    logic signed [SPD_W-1:0]             pid_sh, lft_d, rght_d, lft_q, rght_q;

    always_comb begin
        // 12-bit subtraction wraps on purpose: headings are angles
        err         = bus.actl_hdng - bus.dsrd_hdng;
        err_sat_d   = ERR_W'(sat_s(32'(err), ERR_W));
        abs_err     = (err_sat_d < 0) ? -int'(err_sat_d) : int'(err_sat_d);
        d_diff      = DDIFF_W'(sat_s(32'(err_sat_q) - 32'($signed(d_queue[D_QUEUE_DEPTH-1])), DDIFF_W));
        s2_d.p_term = P_W'(32'(err_sat_q) * P_COEFF);
        s2_d.d_term = D_W'(32'(d_diff) * D_COEFF);
        pid         = PID_W'(32'($signed(s2_q.p_term)) + 32'(i_term) + 32'($signed(s2_q.d_term)));
        pid_sh      = SPD_W'(pid >>> 3);
        lft_d       = SPD_W'(sat_s($signed(32'(bus.frwrd)) + 32'(pid_sh), SPD_W));
        rght_d      = SPD_W'(sat_s($signed(32'(bus.frwrd)) - 32'(pid_sh), SPD_W));
    end

    pid_integrator u_integ (
        .clk    (clk),
        .rst_n  (rst_n),
        .moving (bus.moving),
        .en     (vld_pipe[0]),
        .err    (err_sat_q),
        .i_term (i_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            err_sat_q <= '0;
            at_hdng_q <= 1'b0;
            d_queue   <= '0;
            s2_q      <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], bus.hdng_vld};
            if (bus.hdng_vld) begin
                err_sat_q <= err_sat_d;
                at_hdng_q <= (abs_err < AT_HDNG_THRESH);
            end
            if (vld_pipe[0]) s2_q <= s2_d;
            if (!bus.moving) begin
                d_queue <= '0;
            end else if (vld_pipe[0]) begin
                d_queue[0] <= err_sat_q;
                for (int i = 1; i < D_QUEUE_DEPTH; i++) d_queue[i] <= d_queue[i-1];
            end
            if (vld_pipe[1]) begin
                lft_q  <= bus.moving ? lft_d  : '0;
                rght_q <= bus.moving ? rght_d : '0;
            end
        end
    end

    assign bus.lft_spd  = lft_q;
    assign bus.rght_spd = rght_q;
    assign bus.spd_vld  = vld_pipe[STAGES];
    assign bus.at_hdng  = at_hdng_q;
endmodule
